// File: rtl/pipelined_addsub.sv
// Pipelined ARM-style add/subtract (ADD/ADC/SUB/SBC) with N/Z/C/V flags and valid/ready flow control.
// Optional signed saturation is compiled in with `define ADDSUB_SAT_EN.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_q
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int NMID  = (STAGES > 1) ? STAGES - 1 : 1;

  // Lower chunks of sum are filled in stage by stage; upper chunks of a/b wait their turn.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             cy;
    logic             z;
`ifdef ADDSUB_SAT_EN
    logic             sat;
`endif
  } stage_t;

  stage_t            mid_q   [NMID];
  stage_t            mid_d   [NMID];
  logic [NMID-1:0]   mid_vld_q, mid_vld_d;

  stage_t            st_in   [STAGES];
  stage_t            st_out  [STAGES];
  logic [CHUNK:0]    csum    [STAGES];
  logic [STAGES-1:0] st_vld;

  logic             out_vld_q, out_vld_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             flag_n_q, flag_n_d;
  logic             flag_z_q, flag_z_d;
  logic             flag_c_q, flag_c_d;
  logic             flag_v_q, flag_v_d;
  logic             flag_q_q, flag_q_d;

  logic             stall;
  logic             accept;
  logic [WIDTH-1:0] raw_res;
  logic [WIDTH-1:0] fin_res;
  logic             fin_c, fin_v, fin_z, fin_q, c_msb;

`ifndef ADDSUB_SAT_EN
  logic unused_sat;
  assign unused_sat = sat;
`endif

  assign stall    = out_vld_q & ~out_ready;
  assign in_ready = ~stall & ~rst & ~flush;
  assign accept   = in_valid & in_ready;

  // Carry chain: stage k adds chunk k using the carry registered by stage k-1.
  always_comb begin
    // NOTE: every variable written here gets a full default first, so no latch can be inferred.
    st_in[0]    = '0;
    st_in[0].a  = a;
    st_in[0].b  = op[1] ? ~b : b;
    st_in[0].cy = op[0] ? cin : op[1];
    st_in[0].z  = 1'b1;
`ifdef ADDSUB_SAT_EN
    st_in[0].sat = sat;
`endif
    st_vld    = '0;
    st_vld[0] = accept;
    for (int k = 1; k < STAGES; k++) begin
      st_in[k]  = mid_q[k-1];
      st_vld[k] = mid_vld_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      csum[k] = {1'b0, st_in[k].a[k*CHUNK +: CHUNK]}
              + {1'b0, st_in[k].b[k*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, st_in[k].cy};
      st_out[k]                        = st_in[k];
      st_out[k].sum[k*CHUNK +: CHUNK]  = csum[k][CHUNK-1:0];
      st_out[k].cy                     = csum[k][CHUNK];
      st_out[k].z                      = st_in[k].z & ~(|csum[k][CHUNK-1:0]);
    end
  end

  // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
  always_comb begin
    raw_res = st_out[STAGES-1].sum;
    fin_c   = st_out[STAGES-1].cy;
    c_msb   = raw_res[WIDTH-1] ^ st_out[STAGES-1].a[WIDTH-1] ^ st_out[STAGES-1].b[WIDTH-1];
    fin_v   = c_msb ^ fin_c;
    fin_res = raw_res;
    fin_z   = st_out[STAGES-1].z;
    fin_q   = 1'b0;
`ifdef ADDSUB_SAT_EN
    if (st_out[STAGES-1].sat && fin_v) begin
      fin_res = {~raw_res[WIDTH-1], {(WIDTH-1){raw_res[WIDTH-1]}}};
      fin_z   = 1'b0;
      fin_q   = 1'b1;
    end
`endif
  end

  always_comb begin
    mid_d     = mid_q;
    mid_vld_d = mid_vld_q;
    out_vld_d = out_vld_q;
    result_d  = result_q;
    flag_n_d  = flag_n_q;
    flag_z_d  = flag_z_q;
    flag_c_d  = flag_c_q;
    flag_v_d  = flag_v_q;
    flag_q_d  = flag_q_q;
    if (flush) begin
      mid_vld_d = '0;
      out_vld_d = 1'b0;
      result_d  = '0;
      flag_n_d  = 1'b0;
      flag_z_d  = 1'b0;
      flag_c_d  = 1'b0;
      flag_v_d  = 1'b0;
      flag_q_d  = 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        mid_vld_d[k] = st_vld[k];
        if (st_vld[k]) mid_d[k] = st_out[k];
      end
      out_vld_d = st_vld[STAGES-1];
      // Bubbles leave the last result and flags untouched.
      if (st_vld[STAGES-1]) begin
        result_d = fin_res;
        flag_n_d = fin_res[WIDTH-1];
        flag_z_d = fin_z;
        flag_c_d = fin_c;
        flag_v_d = fin_v;
        flag_q_d = fin_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      mid_vld_q <= '0;
      for (int k = 0; k < NMID; k++) mid_q[k] <= '0;
      out_vld_q <= 1'b0;
      result_q  <= '0;
      flag_n_q  <= 1'b0;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
      flag_v_q  <= 1'b0;
      flag_q_q  <= 1'b0;
    end else begin
      mid_vld_q <= mid_vld_d;
      mid_q     <= mid_d;
      out_vld_q <= out_vld_d;
      result_q  <= result_d;
      flag_n_q  <= flag_n_d;
      flag_z_q  <= flag_z_d;
      flag_c_q  <= flag_c_d;
      flag_v_q  <= flag_v_d;
      flag_q_q  <= flag_q_d;
    end
  end

  assign out_valid = out_vld_q;
  assign result    = result_q;
  assign flag_n    = flag_n_q;
  assign flag_z    = flag_z_q;
  assign flag_c    = flag_c_q;
  assign flag_v    = flag_v_q;
  assign flag_q    = flag_q_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub (WIDTH=32, STAGES=2): directed flag cases, stall,
// async reset, flush and random traffic checked against an arithmetic reference model.
module tb_pipelined_addsub;

  localparam int W = 32;
  localparam int S = 2;
`ifdef ADDSUB_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic         clk;
  logic         rst, flush, in_valid, in_ready, cin, sat;
  logic         out_valid, out_ready;
  logic         flag_n, flag_z, flag_c, flag_v, flag_q;
  logic [1:0]   op;
  logic [W-1:0] a, b, result;

  typedef struct packed {
    logic [W-1:0] res;
    logic n, z, c, v, q;
  } exp_t;

  typedef struct {
    exp_t e;
    int   acc;
  } sb_t;

  sb_t  sb_q[$];
  int   n_checks, n_errors, cyc, hold_cnt;
  bit   lat_chk, accepted, rand_bp;
  exp_t cur_exp;

  pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .cin(cin), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_n(flag_n), .flag_z(flag_z),
    .flag_c(flag_c), .flag_v(flag_v), .flag_q(flag_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] r, input logic n, z, c, v, q);
    exp_t e;
    e.res = r; e.n = n; e.z = z; e.c = c; e.v = v; e.q = q;
    return e;
  endfunction

  // Reference: 33-bit unsigned sum for result/carry, 64-bit signed sum for overflow.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, y,
                                 input logic ci, s);
    exp_t         e;
    logic [W:0]   u;
    longint       sx, sy, st;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00:   begin u = {1'b0, x} + {1'b0, y};                          st = sx + sy; end
      2'b01:   begin u = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};        st = sx + sy + longint'(ci); end
      2'b10:   begin u = {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, 1'b1};     st = sx - sy; end
      default: begin u = {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, ci};       st = sx - sy - 1 + longint'(ci); end
    endcase
    e.res = u[W-1:0];
    e.c   = u[W];
    e.v   = (st > SMAX) || (st < SMIN);
    e.q   = 1'b0;
    if (SAT_EN && s && e.v) begin
      e.res = (st > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      e.q   = 1'b1;
    end
    e.n = e.res[W-1];
    e.z = (e.res == '0);
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h0000_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One clock: sample handshakes on the falling edge, then advance past the rising edge.
  task automatic step();
    sb_t s;
    out_ready = (hold_cnt == 0) && (!rand_bp || ($urandom_range(3) != 0));
    @(negedge clk);
    if (in_valid && in_ready) begin
      sb_q.push_back('{cur_exp, cyc});
      accepted = 1'b1;
    end
    if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) check("unexpected_out", 1, 0);
      else begin
        s = sb_q.pop_front();
        check("result_flags", {result, flag_n, flag_z, flag_c, flag_v, flag_q}, s.e);
        if (lat_chk) check("latency", cyc - s.acc, S);
      end
    end
    @(posedge clk);
    if (hold_cnt > 0) hold_cnt--;
    #1;
  endtask

  task automatic send(input logic [1:0] o, input logic [W-1:0] x, y, input logic ci, s,
                      input exp_t e);
    op = o; a = x; b = y; cin = ci; sat = s; in_valid = 1'b1;
    cur_exp  = e;
    accepted = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) step();
    if (!accepted) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [1:0] o, input logic [W-1:0] x, y, input logic ci, s);
    send(o, x, y, ci, s, model(o, x, y, ci, s));
  endtask

  task automatic send_rnd();
    logic [1:0]   o;
    logic [W-1:0] x, y;
    logic         ci, s;
    o = 2'($urandom_range(3)); x = rnd_val(); y = rnd_val();
    ci = 1'($urandom_range(1)); s = 1'($urandom_range(1));
    send_m(o, x, y, ci, s);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      a = $urandom; b = $urandom; op = 2'($urandom_range(3)); cin = 1'($urandom_range(1));
      step();
    end
  endtask

  task automatic drain(input string tag);
    in_valid = 1'b0;
    for (int i = 0; i < 2000 && sb_q.size() > 0; i++) step();
    check(tag, sb_q.size(), 0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; hold_cnt = 0;
    lat_chk = 1'b0; rand_bp = 1'b0; accepted = 1'b0; cur_exp = '0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 2'b00; a = '0; b = '0; cin = 1'b0; sat = 1'b0;

    #12;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_outputs", {result, flag_n, flag_z, flag_c, flag_v, flag_q}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_reset", in_ready, 1);

    // Directed flag cases, issued back to back.
    lat_chk = 1'b1;
    send(2'b00, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, mk(32'h0, 0, 1, 1, 0, 0));
    send(2'b10, 32'h5, 32'h7, 1'b0, 1'b0, mk(32'hFFFF_FFFE, 1, 0, 0, 0, 0));
    send(2'b11, 32'd10, 32'd3, 1'b0, 1'b0, mk(32'h6, 0, 0, 1, 0, 0));
    send(2'b10, 32'h8000_0000, 32'h1, 1'b0, 1'b0, mk(32'h7FFF_FFFF, 0, 0, 1, 1, 0));
    send(2'b10, 32'h8000_0000, 32'h1, 1'b0, 1'b1,
         SAT_EN ? mk(32'h8000_0000, 1, 0, 1, 1, 1) : mk(32'h7FFF_FFFF, 0, 0, 1, 1, 0));
    send(2'b01, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, mk(32'h8000_0000, 1, 0, 0, 1, 0));
    send(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, mk(32'hFFFF_FFFF, 1, 0, 1, 0, 0));
    send(2'b00, 32'h0000_FFFF, 32'h1, 1'b0, 1'b0, mk(32'h0001_0000, 0, 0, 0, 0, 0));
    send(2'b10, 32'h0, 32'h0, 1'b0, 1'b0, mk(32'h0, 0, 1, 1, 0, 0));
    drain("drain_directed");
    idle(5);
    check("idle_hold", {result, flag_n, flag_z, flag_c, flag_v, flag_q}, mk(32'h0, 0, 1, 1, 0, 0));

    // Six back-to-back ops with the consumer stalled for three cycles mid-stream.
    lat_chk = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) hold_cnt = 3;
      send_rnd();
    end
    drain("drain_stream");

    // Asynchronous reset with two ops in flight.
    send_m(2'b00, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    send_m(2'b10, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_outputs", {result, flag_n, flag_z, flag_c, flag_v, flag_q}, 0);
    check("arst_in_ready", in_ready, 0);
    sb_q.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      check("arst_quiet", out_valid, 0);
    end

    // Synchronous flush with two ops in flight and a third offered on the flush cycle.
    send_m(2'b01, 32'hDEAD_BEEF, 32'h0000_0001, 1'b1, 1'b0);
    send_m(2'b11, 32'h0000_0100, 32'h0000_0001, 1'b1, 1'b0);
    hold_cnt = 1;
    flush = 1'b1;
    in_valid = 1'b1; op = 2'b00; a = 32'h5; b = 32'h5; cur_exp = mk(32'hA, 0, 0, 0, 0, 0);
    #1;
    check("flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_outputs", {result, flag_n, flag_z, flag_c, flag_v, flag_q}, 0);
    sb_q.delete();
    for (int i = 0; i < 6; i++) begin
      idle(1);
      check("flush_quiet", out_valid, 0);
    end
    send(2'b00, 32'h2, 32'h3, 1'b0, 1'b0, mk(32'h5, 0, 0, 0, 0, 0));
    drain("drain_after_flush");

    // Random traffic: first with a free-running consumer (latency checked), then with backpressure.
    lat_chk = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) idle(1);
      send_rnd();
    end
    drain("drain_random");
    lat_chk = 1'b0;
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) idle(1);
      send_rnd();
    end
    drain("drain_backpressure");
    rand_bp = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
